cp0_exc_ctrl: RTL and testbench

Coprocessor-0 exception/interrupt controller for the MIPS pipeline. It holds SR, Cause, EPC and PRId. It detects pending hardware interrupts and synchronous exceptions from the M stage. It drives the single-cycle `req` redirect that forces the IF-stage PC register to the handler entry, and it supplies the EPC target for `eret`.

---
 rtl/cp0_exc_ctrl.sv | 106 ++++++++++
 tb/tb_cp0_exc_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_exc_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cp0_exc_ctrl
// Brief    : Coprocessor-0 exception/interrupt controller. Holds SR, Cause,
//            EPC and PRId, raises the single-cycle fetch redirect and
//            supplies the eret return target.
// Revision : 1.0 - initial release
// ============================================================================
module cp0_exc_ctrl #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
    parameter logic [31:0] PRID_VAL     = 32'h4152_4F4E
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    output logic [31:0] cp0_rdata,
    input  logic [31:0] vpc,
    input  logic        bd_in,
    input  logic [4:0]  exc_code_in,
    input  logic [5:0]  hw_int,
    input  logic        eret_in,
    output logic        req,
    output logic [31:0] epc_out
);

    localparam logic [4:0] c_ADDR_SR    = 5'd12;
    localparam logic [4:0] c_ADDR_CAUSE = 5'd13;
    localparam logic [4:0] c_ADDR_EPC   = 5'd14;
    localparam logic [4:0] c_ADDR_PRID  = 5'd15;

    // SR fields
    logic [5:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    // Cause fields
    logic        r_bd;
    logic [5:0]  r_ip;
    logic [4:0]  r_exc_code;
    // EPC, low two bits held at zero
    logic [31:0] r_epc;

    logic        w_int_req;
    logic        w_exc_req;
    logic [31:0] w_epc_target;

    // Event detection; interrupts win over the synchronous exception when both are present.
    always_comb begin
        w_int_req    = (|(hw_int & r_im)) & r_ie & ~r_exl;
        w_exc_req    = (exc_code_in != 5'd0) & ~r_exl;
        req          = (w_int_req | w_exc_req) & ~reset;
        w_epc_target = bd_in ? (vpc - 32'd4) : vpc;
    end

    // Register update: reset > redirect > (mtc0 then eret) > hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_im       <= 6'd0;
            r_exl      <= 1'b0;
            r_ie       <= 1'b0;
            r_bd       <= 1'b0;
            r_ip       <= 6'd0;
            r_exc_code <= 5'd0;
            r_epc      <= 32'd0;
        end else begin
            r_ip <= hw_int;
            if (req) begin
                r_exl      <= 1'b1;
                r_exc_code <= w_int_req ? 5'd0 : exc_code_in;
                r_bd       <= bd_in;
                r_epc      <= {w_epc_target[31:2], 2'b00};
            end else begin
                if (we && (cp0_addr == c_ADDR_SR)) begin
                    r_im  <= cp0_wdata[15:10];
                    r_exl <= cp0_wdata[1];
                    r_ie  <= cp0_wdata[0];
                end
                if (we && (cp0_addr == c_ADDR_EPC)) begin
                    r_epc <= {cp0_wdata[31:2], 2'b00};
                end
                // Later assignment wins, so eret overrides an SR write to EXL.
                if (eret_in) begin
                    r_exl <= 1'b0;
                end
            end
        end
    end

    // mfc0 read mux, no bypass from a write in flight.
    always_comb begin
        cp0_rdata = 32'd0;
        case (cp0_addr)
            c_ADDR_SR:    cp0_rdata = {16'd0, r_im, 8'd0, r_exl, r_ie};
            c_ADDR_CAUSE: cp0_rdata = {r_bd, 15'd0, r_ip, 3'd0, r_exc_code, 2'd0};
            c_ADDR_EPC:   cp0_rdata = r_epc;
            c_ADDR_PRID:  cp0_rdata = PRID_VAL;
            default:      cp0_rdata = 32'd0;
        endcase
    end

    assign epc_out = r_epc;

endmodule
`default_nettype wire

// File: tb/tb_cp0_exc_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_cp0_exc_ctrl
// Brief    : Self-checking bench for cp0_exc_ctrl: register-level model
//            compared every cycle, plus directed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cp0_exc_ctrl;

    localparam logic [31:0] PRID = 32'h4152_4F4E;

    logic        clk;
    logic        reset;
    logic        we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic [31:0] vpc;
    logic        bd_in;
    logic [4:0]  exc_code_in;
    logic [5:0]  hw_int;
    logic        eret_in;
    logic        req;
    logic [31:0] epc_out;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 0;

    // Architectural model: whole 32-bit registers with read masks.
    logic [31:0] m_sr    = 32'd0;
    logic [31:0] m_cause = 32'd0;
    logic [31:0] m_epc   = 32'd0;

    cp0_exc_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .we          (we),
        .cp0_addr    (cp0_addr),
        .cp0_wdata   (cp0_wdata),
        .cp0_rdata   (cp0_rdata),
        .vpc         (vpc),
        .bd_in       (bd_in),
        .exc_code_in (exc_code_in),
        .hw_int      (hw_int),
        .eret_in     (eret_in),
        .req         (req),
        .epc_out     (epc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_int();
        return ((hw_int & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic logic model_req();
        return (model_int() || ((exc_code_in != 5'd0) && !m_sr[1])) && !reset;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return PRID;
            default: return 32'd0;
        endcase
    endfunction

    // Model state advance on each clock edge.
    always @(posedge clk) begin
        logic [31:0] target;
        if (reset) begin
            m_sr    <= 32'd0;
            m_cause <= 32'd0;
            m_epc   <= 32'd0;
        end else if (model_req()) begin
            target  = bd_in ? vpc - 32'd4 : vpc;
            m_sr    <= m_sr | 32'h2;
            m_cause <= {bd_in, 15'd0, hw_int, 3'd0, (model_int() ? 5'd0 : exc_code_in), 2'd0};
            m_epc   <= target & 32'hFFFF_FFFC;
        end else begin
            logic [31:0] s;
            s = m_sr;
            if (we && cp0_addr == 5'd12) s = cp0_wdata & 32'h0000_FC03;
            if (we && cp0_addr == 5'd14) m_epc <= cp0_wdata & 32'hFFFF_FFFC;
            if (eret_in) s = s & ~32'h2;
            m_sr    <= s;
            m_cause <= (m_cause & ~32'h0000_FC00) | {16'd0, hw_int, 10'd0};
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("req_model", {31'd0, req}, {31'd0, model_req()});
            check("epc_out_model", epc_out, m_epc);
            check("rdata_model", cp0_rdata, model_read(cp0_addr));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string name, input logic [4:0] a, input logic [31:0] exp);
        cp0_addr = a;
        #1;
        check(name, cp0_rdata, exp);
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; cp0_addr = 5'd12; cp0_wdata = 32'd0;
        vpc = 32'd0; bd_in = 1'b0; exc_code_in = 5'd0; hw_int = 6'd0; eret_in = 1'b0;
        tick();
        tick();
        cmp_en = 1'b1;
        @(negedge clk);
        rd("rst_sr", 5'd12, 32'd0);
        rd("rst_cause", 5'd13, 32'd0);
        rd("rst_epc", 5'd14, 32'd0);
        check("rst_req", {31'd0, req}, 32'd0);
        tick();
        reset = 1'b0;

        // Synchronous exception
        tick();
        exc_code_in = 5'd4; vpc = 32'h0000_3010; bd_in = 1'b0;
        @(negedge clk);
        check("exc_req", {31'd0, req}, 32'd1);
        tick();
        exc_code_in = 5'd0;
        @(negedge clk);
        check("exc_req_drop", {31'd0, req}, 32'd0);
        rd("exc_sr", 5'd12, 32'h0000_0002);
        rd("exc_cause", 5'd13, 32'h0000_0010);
        rd("exc_epc", 5'd14, 32'h0000_3010);
        tick();
        eret_in = 1'b1;
        tick();
        eret_in = 1'b0;

        // Interrupt in a delay slot
        we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0401;
        tick();
        we = 1'b0; hw_int = 6'b000001; vpc = 32'h0000_3024; bd_in = 1'b1;
        @(negedge clk);
        check("int_req", {31'd0, req}, 32'd1);
        tick();
        @(negedge clk);
        check("int_req_once", {31'd0, req}, 32'd0);
        rd("int_cause", 5'd13, 32'h8000_0400);
        rd("int_epc", 5'd14, 32'h0000_3020);

        // Nested exception ignored while EXL set
        hw_int = 6'b111111; exc_code_in = 5'd10;
        tick();
        @(negedge clk);
        check("nest_req", {31'd0, req}, 32'd0);
        tick();
        exc_code_in = 5'd0; eret_in = 1'b1;
        @(negedge clk);
        rd("nest_cause", 5'd13, 32'h8000_FC00);
        rd("nest_epc", 5'd14, 32'h0000_3020);
        tick();
        eret_in = 1'b0;
        @(negedge clk);
        check("eret_reint_req", {31'd0, req}, 32'd1);
        tick();
        hw_int = 6'd0; bd_in = 1'b0;
        eret_in = 1'b1;
        tick();
        eret_in = 1'b0;

        // Interrupt + exception + mtc0 EPC in one cycle
        hw_int = 6'b000001; exc_code_in = 5'd12; vpc = 32'h0000_3040;
        we = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("prio_req", {31'd0, req}, 32'd1);
        tick();
        hw_int = 6'd0; exc_code_in = 5'd0; we = 1'b0;
        @(negedge clk);
        check("prio_epc_out", epc_out, 32'h0000_3040);
        rd("prio_cause", 5'd13, 32'h0000_0400);
        tick();
        eret_in = 1'b1;
        tick();
        eret_in = 1'b0;

        // mtc0 EPC masking, read-only Cause, PRId, unimplemented
        hw_int = 6'b000010;
        we = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h0000_3007;
        tick();
        we = 1'b0;
        @(negedge clk);
        rd("mtc0_epc", 5'd14, 32'h0000_3004);
        check("mtc0_epc_out", epc_out, 32'h0000_3004);
        tick();
        we = 1'b1; cp0_addr = 5'd13; cp0_wdata = 32'hFFFF_FFFF;
        tick();
        we = 1'b0;
        @(negedge clk);
        rd("cause_ro", 5'd13, 32'h0000_0800);
        rd("prid", 5'd15, PRID);
        rd("unimpl", 5'd3, 32'd0);

        // mtc0 SR with eret: EXL ends clear
        tick();
        we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'hFFFF_FC03; eret_in = 1'b1;
        tick();
        we = 1'b0; eret_in = 1'b0;
        @(negedge clk);
        rd("sr_we_eret", 5'd12, 32'h0000_FC01);

        // IE enabled by mtc0 while interrupt pending
        tick();
        we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0000;
        tick();
        hw_int = 6'b000001; cp0_wdata = 32'h0000_0401;
        @(negedge clk);
        check("ie_en_before", {31'd0, req}, 32'd0);
        tick();
        we = 1'b0;
        @(negedge clk);
        check("ie_en_after", {31'd0, req}, 32'd1);
        tick();
        hw_int = 6'd0;

        // Reset together with a qualifying exception
        tick();
        reset = 1'b1; exc_code_in = 5'd4;
        @(negedge clk);
        check("rst_exc_req", {31'd0, req}, 32'd0);
        tick();
        reset = 1'b0; exc_code_in = 5'd0;
        @(negedge clk);
        rd("rst2_sr", 5'd12, 32'd0);
        rd("rst2_cause", 5'd13, 32'd0);
        rd("rst2_epc", 5'd14, 32'd0);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
